// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the divided-clock ratio meter.
package clk_meter_pkg;

    localparam int unsigned CNT_WIDTH_DEF = 8;
    localparam logic [CNT_WIDTH_DEF-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS,
        DONE
    } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a registered copy; flags rising edges of the synchronized level.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a divided clock in reference cycles and checks the period
// against an expected divide ratio; counter saturation ends a measurement as a timeout.
module clk_ratio_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst,
    input  logic                 i_meas_clk,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_exp_ratio,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic [CNT_WIDTH-1:0] o_high,
    output logic                 o_match,
    output logic                 o_timeout
);

    localparam logic [CNT_WIDTH-1:0] CNT_SAT = '1;

    meter_state_t         state;
    meter_state_t         state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] high_cnt;
    logic [CNT_WIDTH-1:0] exp_ratio;
    logic                 level;
    logic                 rise;
    logic                 meas_done;
    logic                 meas_tmo;

    sync_edge_det u_sync (
        .clk   (i_ref_clk),
        .rst   (i_rst),
        .din   (i_meas_clk),
        .level (level),
        .rise  (rise)
    );

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        meas_done = 1'b0;
        meas_tmo  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    state_nxt = MEAS;
                end else if (cnt == CNT_SAT) begin
                    meas_tmo  = 1'b1;
                    state_nxt = DONE;
                end
            end
            MEAS: begin
                if (rise) begin
                    meas_done = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == CNT_SAT) begin
                    meas_tmo  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // high_cnt never exceeds cnt, so only cnt needs the saturation guard.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            high_cnt  <= '0;
            exp_ratio <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        exp_ratio <= i_exp_ratio;
                        cnt       <= '0;
                        high_cnt  <= '0;
                    end
                end
                ARM: begin
                    if (rise) begin
                        cnt      <= CNT_WIDTH'(1);
                        high_cnt <= CNT_WIDTH'(1);
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MEAS: begin
                    if (!rise && cnt != CNT_SAT) begin
                        cnt <= cnt + 1'b1;
                        if (level) begin
                            high_cnt <= high_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
            o_period  <= '0;
            o_high    <= '0;
            o_match   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_busy  <= (state_nxt == ARM) || (state_nxt == MEAS);
            o_valid <= meas_done || meas_tmo;
            if (meas_done) begin
                o_period  <= cnt;
                o_high    <= high_cnt;
                o_match   <= (cnt == exp_ratio);
                o_timeout <= 1'b0;
            end else if (meas_tmo) begin
                o_period  <= '0;
                o_high    <= '0;
                o_match   <= 1'b0;
                o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: a reference model derives results and o_valid timing
// from the bench's own divided-clock waveform history.
module tb_clk_ratio_meter;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       meas   = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] exp_in = '0;
    logic       busy;
    logic       valid;
    logic       match;
    logic       tmo;
    logic [7:0] per;
    logic [7:0] hi;

    clk_ratio_meter #(.CNT_WIDTH(8)) dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_meas_clk  (meas),
        .i_start     (start),
        .i_exp_ratio (exp_in),
        .o_busy      (busy),
        .o_valid     (valid),
        .o_period    (per),
        .o_high      (hi),
        .o_match     (match),
        .o_timeout   (tmo)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int ratio = 2;
    bit en    = 0;
    int ph    = 0;
    bit lvl [0:8191];
    int n_cmp = 0;
    int n_bad = 0;

    // Bench-side divider: high for ratio/2 cycles, low for the rest; level logged per cycle.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (!en) begin
            ph   = 0;
            meas = 1'b0;
        end else begin
            meas = (ph < ratio / 2);
            ph   = (ph + 1 >= ratio) ? 0 : ph + 1;
        end
        if (cyc < 8192) lvl[cyc] = meas;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, got, want);
        end
    endtask

    bit  pend   = 0;
    int  sa     = 0;
    int  ea     = 0;
    int  last_v = -10;
    int  h_per  = 0;
    int  h_hi   = 0;
    int  h_match = 0;
    int  h_to   = 0;
    int  c, r1, r2, m_per, m_hi;
    bit  ev, m_to;

    // A meas rise in cycle r is detected in cycle r+2; the run ends one cycle after detection.
    always @(negedge clk) begin
        c = cyc;
        if (rst) begin
            pend = 0; h_per = 0; h_hi = 0; h_match = 0; h_to = 0;
            chk("reset_outputs", {busy, valid, match, tmo, per, hi}, 0);
        end else begin
            ev = 0; m_to = 0; m_per = 0; m_hi = 0;
            if (pend) begin
                r1 = -1; r2 = -1;
                for (int r = sa - 1; r <= c - 3; r++) begin
                    if (r >= 1 && r < 8192 && lvl[r] && !lvl[r-1]) begin
                        if (r1 < 0) begin
                            if (r <= sa + 254) r1 = r;
                        end else if (r2 < 0 && r <= r1 + 255) begin
                            r2 = r;
                        end
                    end
                end
                if (r1 < 0) begin
                    ev = (c == sa + 257); m_to = 1;
                end else if (r2 < 0) begin
                    ev = (c == r1 + 258); m_to = 1;
                end else begin
                    ev    = (c == r2 + 3);
                    m_per = r2 - r1;
                    for (int k = r1; k < r2; k++) m_hi += int'(lvl[k]);
                end
            end
            chk("valid", valid, ev);
            chk("busy", busy, pend && c > sa && !ev);
            if (ev) begin
                h_per   = m_per;
                h_hi    = m_hi;
                h_to    = m_to;
                h_match = (!m_to && m_per == ea) ? 1 : 0;
                pend    = 0;
                last_v  = c;
            end
            chk("period", per, h_per);
            chk("high", hi, h_hi);
            chk("match", match, h_match);
            chk("timeout", tmo, h_to);
            if (start && !pend && c != last_v) begin
                pend = 1; sa = c; ea = exp_in;
            end
        end
    end

    int g_per, g_hi, g_match, g_to, g_lat;

    task automatic set_div(input int r, input bit e);
        @(negedge clk);
        ratio = r; en = e; ph = 0;
        repeat (12) @(posedge clk);
    endtask

    task automatic run(input logic [7:0] e, input bit poke);
        int s;
        bit seen = 0;
        @(posedge clk); #1;
        start = 1'b1; exp_in = e; s = cyc;
        for (int k = 0; k < 700 && !seen; k++) begin
            @(posedge clk); #1;
            start = poke && (k == 3);
            if (start) exp_in = 8'd9;
            @(negedge clk);
            if (valid === 1'b1) begin
                seen = 1; g_lat = cyc - s;
                g_per = per; g_hi = hi; g_match = match; g_to = tmo;
            end
        end
        start = 1'b0;
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL run_done: got no o_valid, want one within 700 cycles (exp=%0d)", e);
        end
    endtask

    task automatic lit(input string tag, input int p, input int h, input int m, input int t);
        chk({tag, "_period"}, g_per, p);
        chk({tag, "_high"}, g_hi, h);
        chk({tag, "_match"}, g_match, m);
        chk({tag, "_timeout"}, g_to, t);
    endtask

    initial begin
        int s;
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;

        set_div(2, 1); run(8'd2, 0); lit("r2", 2, 1, 1, 0);
        set_div(4, 1); run(8'd4, 0); lit("r4", 4, 2, 1, 0);
        run(8'd6, 0);  lit("r4x6", 4, 2, 0, 0);
        set_div(3, 1); run(8'd3, 0); lit("r3", 3, 1, 1, 0);
        chk("r3_high_lt_period", (g_hi < g_per) ? 1 : 0, 1);
        set_div(7, 1); run(8'd7, 0); lit("r7", 7, 3, 1, 0);
        chk("r7_high_lt_period", (g_hi < g_per) ? 1 : 0, 1);

        set_div(2, 0); run(8'd8, 0); lit("off", 0, 0, 0, 1);
        chk("off_latency", g_lat, 257);

        set_div(8, 1);
        @(posedge clk); #1;
        start = 1'b1; exp_in = 8'd8; s = cyc;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk); chk("pre_rst_busy", busy, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); chk("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        set_div(6, 1); run(8'd6, 0); lit("r6", 6, 3, 1, 0);

        set_div(5, 1); run(8'd5, 1); lit("r5poke", 5, 2, 1, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
